// File: rtl/apb_queued_master.sv
// rtl/apb_queued_master.sv - APB4 requester: queued commands run in order; responses return through a FIFO.
module apb_queued_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            pclk,
    input  logic            prst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_strb,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_slverr,
    output logic            rsp_timeout,
    output logic            busy,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [AW-1:0]   paddr,
    output logic [DW-1:0]   pwdata,
    output logic [DW/8-1:0] pstrb,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslverr
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = DW / 8;
    localparam int CW = 1 + AW + DW + SW;
    localparam int RW = DW + 2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cmd_mem [DEPTH];
    logic [RW-1:0]   r_rsp_mem [DEPTH];
    logic [PW:0]     r_cmd_wp, r_cmd_rp, r_rsp_wp, r_rsp_rp;
    logic [TW-1:0]   r_tcnt;
    logic            r_psel, r_penable, r_pwrite;
    logic [AW-1:0]   r_paddr;
    logic [DW-1:0]   r_pwdata;
    logic [SW-1:0]   r_pstrb;

    logic            w_cmd_empty, w_cmd_full, w_cmd_push;
    logic            w_rsp_empty, w_rsp_push, w_rsp_pop;
    logic [PW:0]     w_rsp_cnt;
    logic            w_credit, w_launch, w_tmo;
    logic [CW-1:0]   w_cmd_head;
    logic [RW-1:0]   w_rsp_head, w_rsp_din;
    logic            w_h_write;
    logic [AW-1:0]   w_h_addr;
    logic [DW-1:0]   w_h_wdata;
    logic [SW-1:0]   w_h_strb;

    assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full  = ((r_cmd_wp ^ r_cmd_rp) == {1'b1, {PW{1'b0}}});
    assign w_cmd_push  = cmd_valid && !w_cmd_full;
    assign w_cmd_head  = r_cmd_mem[r_cmd_rp[PW-1:0]];
    assign {w_h_write, w_h_addr, w_h_wdata, w_h_strb} = w_cmd_head;

    assign w_rsp_empty = (r_rsp_wp == r_rsp_rp);
    assign w_rsp_cnt   = r_rsp_wp - r_rsp_rp;
    assign w_rsp_pop   = !w_rsp_empty && rsp_ready;
    assign w_rsp_head  = r_rsp_mem[r_rsp_rp[PW-1:0]];

    // A transfer launches only if a response slot is reserved for it and for the one still in flight.
    assign w_credit = ({1'b0, w_rsp_cnt} + {{(PW + 1){1'b0}}, (r_state != S_IDLE)})
                      < (PW + 2)'(DEPTH);

    assign w_rsp_din = w_tmo ? {{DW{1'b0}}, 1'b1, 1'b1}
                             : {(r_pwrite ? {DW{1'b0}} : prdata), pslverr, 1'b0};

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_rsp_push  = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cmd_empty && w_credit) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    w_rsp_push = 1'b1;
                    if (!w_cmd_empty && w_credit) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (TIMEOUT != 0 && r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_rsp_push  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_tcnt    <= '0;
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= (w_state_nxt != S_IDLE);
            r_penable <= (w_state_nxt == S_ACCESS);
            if (w_launch) begin
                r_pwrite <= w_h_write;
                r_paddr  <= w_h_addr;
                r_pwdata <= w_h_write ? w_h_wdata : '0;
                r_pstrb  <= w_h_write ? w_h_strb : '0;
            end
            if (r_state == S_SETUP) begin
                r_tcnt <= '0;
            end else if (r_state == S_ACCESS && !pready) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
            if (w_launch)   r_cmd_rp <= r_cmd_rp + 1'b1;
            if (w_rsp_push) r_rsp_wp <= r_rsp_wp + 1'b1;
            if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge pclk) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wp[PW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
        if (w_rsp_push) r_rsp_mem[r_rsp_wp[PW-1:0]] <= w_rsp_din;
    end

    assign cmd_ready   = !w_cmd_full;
    assign rsp_valid   = !w_rsp_empty;
    assign rsp_rdata   = rsp_valid ? w_rsp_head[RW-1:2] : '0;
    assign rsp_slverr  = rsp_valid && w_rsp_head[1];
    assign rsp_timeout = rsp_valid && w_rsp_head[0];
    assign busy        = !w_cmd_empty || (r_state != S_IDLE);
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
endmodule

// File: tb/tb_apb_queued_master.sv
// tb/tb_apb_queued_master.sv - Directed scenarios for apb_queued_master with a wait-state APB slave model.
module tb_apb_queued_master;
    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr = 1'b0;

    logic        stuck = 1'b0;
    int          wait_states = 0;
    int          acc_cnt = 0;
    logic [31:0] prdata_base = '0;
    int          checks = 0, errors = 0;
    int          xfer_cnt = 0, psel_rises = 0;
    logic        prev_psel = 1'b0;
    logic [31:0] rsp_q[$];

    apb_queued_master #(.DW(32), .AW(32), .DEPTH(4), .TIMEOUT(16)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave model: pready rises after wait_states ACCESS cycles; read data is derived from the address.
    assign pready = !stuck && (acc_cnt >= wait_states);
    assign prdata = prdata_base + paddr;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(negedge pclk) begin
        prev_psel <= psel;
        if (psel && !prev_psel) psel_rises <= psel_rises + 1;
        if (psel && penable && pready) xfer_cnt <= xfer_cnt + 1;
        if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int budget, output logic ok);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) begin
                tick(1);
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (psel !== 1'b0) begin errors++; $display("FAIL reset_psel: got %0b want 0", psel); end
        checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable: got %0b want 0", penable); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if ({paddr, pwdata, pstrb, pwrite} !== 69'd0) begin errors++; $display("FAIL reset_payload: got %h want 0", {paddr, pwdata, pstrb, pwrite}); end
        checks++; if ({rsp_rdata, rsp_slverr, rsp_timeout} !== 34'd0) begin errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_rdata, rsp_slverr, rsp_timeout}); end
        prst_n = 1'b1;
        tick(2);
        checks++; if (psel !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset: psel %0b cmd_ready %0b want 0/1", psel, cmd_ready); end
    endtask

    task automatic test_write();
        logic ok;
        wait_states = 0; stuck = 1'b0; pslverr = 1'b0;
        offer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 5, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_accept: got %0b want 1", ok); end
        checks++; if (psel !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_e0: psel %0b busy %0b want 0/1", psel, busy); end
        tick(1);
        checks++; if (psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup: psel %0b penable %0b want 1/0", psel, penable); end
        checks++; if (paddr !== 32'h10 || pwdata !== 32'hDEADBEEF || pstrb !== 4'hF || pwrite !== 1'b1) begin
            errors++; $display("FAIL wr_payload: addr %h data %h strb %h wr %0b", paddr, pwdata, pstrb, pwrite); end
        tick(1);
        checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wr_access: psel %0b penable %0b rsp_valid %0b want 1/1/0", psel, penable, rsp_valid); end
        tick(1);
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL wr_done_bus: psel %0b penable %0b want 0/0", psel, penable); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: valid %0b rdata %h err %0b to %0b want 1/0/0/0", rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout); end
        pop_one();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_drain: rsp_valid %0b busy %0b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_read_wait();
        logic ok;
        int en_cnt, lat;
        logic [3:0] strb_seen;
        logic [31:0] wdata_seen;
        wait_states = 3;
        prdata_base = 32'hA5A50001 - 32'h24;
        en_cnt = 0; lat = -1; strb_seen = 4'hA; wdata_seen = 32'h1;
        offer(1'b0, 32'h24, 32'h12345678, 4'hF, 5, ok);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 1) begin strb_seen = pstrb; wdata_seen = pwdata; end
            if (penable) en_cnt++;
            if (rsp_valid) begin lat = i; break; end
        end
        checks++; if (en_cnt != 4) begin errors++; $display("FAIL rd_penable_cycles: got %0d want 4", en_cnt); end
        checks++; if (lat != 6) begin errors++; $display("FAIL rd_latency: got %0d want 6", lat); end
        checks++; if (strb_seen !== 4'h0 || wdata_seen !== 32'h0) begin errors++; $display("FAIL rd_strb_wdata: strb %h wdata %h want 0/0", strb_seen, wdata_seen); end
        checks++; if (rsp_rdata !== 32'hA5A50001 || rsp_slverr !== 1'b0) begin errors++; $display("FAIL rd_rdata: got %h err %0b want a5a50001/0", rsp_rdata, rsp_slverr); end
        pop_one();
        wait_states = 0;
    endtask

    task automatic test_fill();
        logic ok;
        int acc, x0, q0, got;
        prdata_base = 32'h50000000;
        acc = 0; x0 = xfer_cnt; q0 = rsp_q.size();
        for (int k = 0; k < 8; k++) begin
            offer(1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 20, ok);
            if (ok) acc++;
        end
        checks++; if (acc != 8) begin errors++; $display("FAIL fill_accepted: got %0d want 8", acc); end
        offer(1'b0, 32'h120, 32'h0, 4'h0, 20, ok);
        checks++; if (ok !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_stall: accepted %0b cmd_ready %0b want 0/0", ok, cmd_ready); end
        checks++; if (xfer_cnt - x0 != 4) begin errors++; $display("FAIL fill_transfers: got %0d want 4", xfer_cnt - x0); end
        checks++; if (psel !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL fill_idle: psel %0b rsp_valid %0b want 0/1", psel, rsp_valid); end
        rsp_ready = 1'b1;
        offer(1'b0, 32'h120, 32'h0, 4'h0, 40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_ninth: got %0b want 1", ok); end
        for (int i = 0; i < 100 && (rsp_q.size() - q0) < 9; i++) tick(1);
        rsp_ready = 1'b0;
        got = rsp_q.size() - q0;
        checks++; if (got != 9) begin errors++; $display("FAIL fill_rsp_count: got %0d want 9", got); end
        for (int k = 0; k < 9 && k < got; k++) begin
            checks++; if (rsp_q[q0 + k] !== 32'h50000100 + 32'(4 * k)) begin
                errors++; $display("FAIL fill_order[%0d]: got %h want %h", k, rsp_q[q0 + k], 32'h50000100 + 32'(4 * k)); end
        end
    endtask

    task automatic test_timeout();
        logic ok;
        int en_cnt;
        stuck = 1'b1; en_cnt = 0;
        offer(1'b1, 32'h30, 32'h11, 4'h3, 5, ok);
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (penable) en_cnt++;
            if (rsp_valid) break;
        end
        checks++; if (en_cnt != 16) begin errors++; $display("FAIL to_cycles: got %0d want 16", en_cnt); end
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL to_bus_drop: psel %0b penable %0b want 0/0", psel, penable); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_slverr !== 1'b1 || rsp_timeout !== 1'b1) begin
            errors++; $display("FAIL to_rsp: rdata %h err %0b to %0b want 0/1/1", rsp_rdata, rsp_slverr, rsp_timeout); end
        stuck = 1'b0;
        pop_one();
        tick(2);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_late_pready: rsp_valid %0b busy %0b want 0/0", rsp_valid, busy); end
        offer(1'b1, 32'h34, 32'h22, 4'hF, 5, ok);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick(1);
        checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL to_recover: valid %0b err %0b to %0b want 1/0/0", rsp_valid, rsp_slverr, rsp_timeout); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic ok;
        int r0, x0;
        pslverr = 1'b1; r0 = psel_rises; x0 = xfer_cnt;
        for (int k = 0; k < 4; k++) offer(1'b1, 32'h40 + 32'(4 * k), 32'(k), 4'hF, 5, ok);
        for (int i = 0; i < 40 && busy; i++) tick(1);
        tick(1);
        checks++; if (psel_rises - r0 != 1) begin errors++; $display("FAIL b2b_psel_rises: got %0d want 1", psel_rises - r0); end
        checks++; if (xfer_cnt - x0 != 4) begin errors++; $display("FAIL b2b_transfers: got %0d want 4", xfer_cnt - x0); end
        checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b1 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL b2b_slverr: valid %0b err %0b to %0b want 1/1/0", rsp_valid, rsp_slverr, rsp_timeout); end
        pslverr = 1'b0;
        rsp_ready = 1'b1;
        tick(5);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: rsp_valid %0b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int r0;
        stuck = 1'b1;
        for (int k = 0; k < 3; k++) offer(1'b1, 32'h80 + 32'(4 * k), 32'hFF, 4'hF, 5, ok);
        for (int i = 0; i < 10 && !penable; i++) tick(1);
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access: penable %0b want 1", penable); end
        #2 prst_n = 1'b0;
        #1;
        checks++; if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== 71'd0) begin
            errors++; $display("FAIL rst_mid_apb: got %h want 0", {psel, penable, pwrite, paddr, pwdata, pstrb}); end
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fifo: rsp_valid %0b cmd_ready %0b busy %0b want 0/1/0", rsp_valid, cmd_ready, busy); end
        stuck = 1'b0;
        tick(2);
        prst_n = 1'b1;
        r0 = psel_rises;
        tick(10);
        checks++; if (psel_rises != r0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet: psel_rises %0d rsp_valid %0b want 0/0", psel_rises - r0, rsp_valid); end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_write();
        test_read_wait();
        test_fill();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_queued_master.md
# apb_queued_master

Synthesizable APB4 requester that replaces task-driven, one-transfer-at-a-time APB stimulus with a queued command/response engine. Commands enter through a valid/ready command FIFO, execute strictly in order on the APB bus with wait-state and timeout handling, and return through a valid/ready response FIFO. It sits between any on-chip or bench-side sequencer and an APB slave such as the crypto accelerator register file.

## Interface
- DW, 32, data width; multiple of 8.
- AW, 32, address width.
- DEPTH, 4, entries in each FIFO; power of 2, at least 2.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

- pclk  in  1  clock.
- prst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  address.
- cmd_wdata  in  DW  write data.
- cmd_strb  in  DW/8  write strobes.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DW  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  pslverr captured, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  command FIFO non-empty or FSM not IDLE.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  AW, pwdata  out  DW, pstrb  out  DW/8  APB payload.
- prdata  in  DW, pready  in  1, pslverr  in  1  APB completion.

## Operation
- Command FIFO: a push occurs when cmd_valid && cmd_ready. cmd_ready = !full. No same-cycle pass-through.
- FSM states:
  - IDLE: psel=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- IDLE -> SETUP when the command FIFO is non-empty and credit is available. On this transition the FSM pops the head entry and registers paddr, pwrite, pwdata and pstrb.
- Credit rule: response FIFO occupancy + transfers in flight < DEPTH. This guarantees every launched transfer has a response slot.
- SETUP -> ACCESS unconditionally.
- ACCESS completes on an edge where pready=1:
  - Pushes {prdata for reads / 0 for writes, pslverr, timeout=0} into the response FIFO.
  - Goes to SETUP if the launch condition holds (back-to-back, psel stays high, penable drops); otherwise goes to IDLE.
- Reads drive pstrb=0 and pwdata=0.
- Timeout counter:
  - Cleared on entry to ACCESS; increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT, the transfer aborts: next state IDLE and response {0, 1, 1} is pushed.
  - A later pready is ignored.
- Response FIFO: simultaneous push and pop is legal, including when full; occupancy is unchanged.
- Ordering: responses are returned strictly in command order.
- paddr, pwrite, pwdata and pstrb hold their values while psel=1. Outside a transfer they keep their last value.

## Timing
- Reset (asynchronous, immediate):
  - All outputs are 0 except cmd_ready, which is 1 (FIFOs are empty).
  - FIFOs are emptied, FSM goes to IDLE, timeout counter clears.
- All APB outputs are registered.
- Command accepted at edge E0:
  - psel=1 after E1.
  - penable=1 after E2.
  - Zero-wait completion at E3.
  - rsp_valid=1 after E3.
  - Total latency is 3 cycles plus wait states.
- Back-to-back throughput is 2 cycles per transfer when there are no wait states.
- Reset mid-transfer: psel and penable drop asynchronously. The in-flight transfer and all queued entries are discarded, and no response is produced.
- Timeout abort: psel and penable are low the cycle after the TIMEOUT-th wait cycle.

## Test plan
- Write 0x10 / 0xDEADBEEF / strb 0xF with pready=1 -> psel high 2 cycles, penable high 1 cycle, pstrb=0xF, response {0x0, slverr 0, timeout 0} valid 3 cycles after accept.
- Read 0x24 with 3 wait states, prdata=0xA5A50001 -> penable high 4 cycles, pstrb=0, rsp_rdata=0xA5A50001.
- DEPTH=4, rsp_ready=0, push 9 commands -> exactly 4 APB transfers, 4 commands queued, cmd_ready low with the 9th command stalled. Then set rsp_ready=1 -> all 9 responses return in order.
- TIMEOUT=16, pready stuck 0 -> abort after 16 ACCESS cycles, response {0, 1, 1}. A following write with pready=1 completes normally.
- Write with pslverr=1 at completion -> rsp_slverr=1, rsp_timeout=0. With 4 back-to-back commands, psel stays high with no IDLE cycles.
- Assert prst_n low during ACCESS with 2 commands queued -> all APB outputs 0 immediately, rsp_valid=0, cmd_ready=1, and no APB activity after release.
